// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller.
// Provides the FSM state enum and the accepted coin values.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        VEND    = 3'd2,
        CHANGE  = 3'd3,
        REFUND  = 3'd4
    } vend_state_t;

    localparam int COIN_5_VAL  = 5;
    localparam int COIN_10_VAL = 10;

endpackage

// File: rtl/vend_timer.sv
// Dispense watchdog: cleared by load, advances while count is high,
// expire is high in the TIMEOUT-th consecutive counting cycle.
// Ports: clk, reset_n, load, count -> expire.
module vend_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic count,
    output logic expire
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (count && cnt != LAST) begin
            cnt <= cnt + 8'd1;
        end
    end

    // cnt holds (cycles already spent counting), so LAST marks the final one
    assign expire = count && (cnt == LAST);

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: collects 5/10 coins, vends at PRICE, pays change
// or refunds one 5-unit coin every other cycle.
// Ports: clk, reset_n, coin_5, coin_10, cancel, dispense_done ->
//        dispense_req, change_5, coin_reject, vend_fault, busy, credit[5:0].
// Build option: VEND_TIMEOUT_EN adds a dispense watchdog (vend_timer)
// that aborts a stuck vend after TIMEOUT cycles and refunds the credit.
module vend_ctrl #(
    parameter int PRICE      = 25,
    parameter int MAX_CREDIT = 40,
    parameter int TIMEOUT    = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       coin_5,
    input  logic       coin_10,
    input  logic       cancel,
    input  logic       dispense_done,
    output logic       dispense_req,
    output logic       change_5,
    output logic       coin_reject,
    output logic       vend_fault,
    output logic       busy,
    output logic [5:0] credit
);

    import vend_pkg::*;

    localparam logic [6:0] PRICE_W = 7'(PRICE);
    localparam logic [6:0] MAX_W   = 7'(MAX_CREDIT);
    localparam logic [6:0] C5_W    = 7'(COIN_5_VAL);
    localparam logic [6:0] C10_W   = 7'(COIN_10_VAL);
    localparam logic [5:0] PRICE_6 = 6'(PRICE);
    localparam logic [5:0] C5_6    = 6'(COIN_5_VAL);

    vend_state_t state, state_n;
    logic [5:0]  credit_n;
    logic [6:0]  sum, add;
    logic        phase, phase_n;
    logic        chg_n, rej_n;
    logic        any_coin;

    assign any_coin = coin_5 | coin_10;

`ifdef VEND_TIMEOUT_EN
    logic expire;
    logic fault_n;

    vend_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (state != VEND),
        .count  (state == VEND),
        .expire (expire)
    );
`endif

    always_comb begin
        state_n  = state;
        credit_n = credit;
        phase_n  = phase;
        chg_n    = 1'b0;
        rej_n    = 1'b0;
        sum      = {1'b0, credit};
        add      = '0;
`ifdef VEND_TIMEOUT_EN
        fault_n  = 1'b0;
`endif
        unique case (state)
            IDLE, COLLECT: begin
                if (cancel && state == COLLECT) begin
                    // cancel wins; any coin this cycle bounces
                    state_n = REFUND;
                    phase_n = 1'b0;
                    rej_n   = any_coin;
                end else begin
                    if (coin_10) begin
                        if (sum + C10_W <= MAX_W) add = C10_W;
                        else                      rej_n = 1'b1;
                    end
                    if (coin_5) begin
                        // a simultaneous 10 always takes the slot
                        if (coin_10 || (sum + C5_W > MAX_W)) rej_n = 1'b1;
                        else                                 add = C5_W;
                    end
                    sum      = sum + add;
                    credit_n = sum[5:0];
                    if (sum >= PRICE_W)    state_n = VEND;
                    else if (sum != '0)    state_n = COLLECT;
                end
            end
            VEND: begin
                rej_n = any_coin;
                if (dispense_done) begin
                    credit_n = credit - PRICE_6;
                    phase_n  = 1'b0;
                    state_n  = (credit_n != '0) ? CHANGE : IDLE;
                end
`ifdef VEND_TIMEOUT_EN
                else if (expire) begin
                    fault_n = 1'b1;
                    phase_n = 1'b0;
                    state_n = REFUND;
                end
`endif
            end
            CHANGE, REFUND: begin
                rej_n = any_coin;
                if (credit == '0) begin
                    state_n = IDLE;
                end else if (!phase) begin
                    // high half of the pulse: pay out one coin
                    chg_n    = 1'b1;
                    credit_n = credit - C5_6;
                    phase_n  = 1'b1;
                    if (credit == C5_6) state_n = IDLE;
                end else begin
                    phase_n = 1'b0;
                end
            end
            default: begin
                state_n  = IDLE;
                credit_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            credit       <= '0;
            phase        <= 1'b0;
            dispense_req <= 1'b0;
            change_5     <= 1'b0;
            coin_reject  <= 1'b0;
        end else begin
            state        <= state_n;
            credit       <= credit_n;
            phase        <= phase_n;
            dispense_req <= (state_n == VEND);
            change_5     <= chg_n;
            coin_reject  <= rej_n;
        end
    end

`ifdef VEND_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vend_fault <= 1'b0;
        else          vend_fault <= fault_n;
    end
`else
    assign vend_fault = 1'b0;
`endif

    assign busy = (state == VEND) || (state == CHANGE) || (state == REFUND);

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: vector table, directed corner
// sequences and a randomized run against a behavioural credit model.
module tb_vend_ctrl;

    localparam int PRICE      = 25;
    localparam int MAX_CREDIT = 40;
    localparam int TIMEOUT    = 16;
`ifdef VEND_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    localparam int M_OPEN = 0;
    localparam int M_VEND = 1;
    localparam int M_PAY  = 2;

    logic       clk;
    logic       reset_n;
    logic       coin_5, coin_10, cancel, dispense_done;
    logic       dispense_req, change_5, coin_reject, vend_fault, busy;
    logic [5:0] credit;
    logic       dreq2, chg2, rej2, fault2, busy2;
    logic [5:0] credit2;

    int checks   = 0;
    int failures = 0;

    int m_mode, m_credit, m_age;
    bit m_gap, m_chg, m_rej, m_fault;

    vend_ctrl #(
        .PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .coin_5(coin_5), .coin_10(coin_10),
        .cancel(cancel), .dispense_done(dispense_done),
        .dispense_req(dispense_req), .change_5(change_5),
        .coin_reject(coin_reject), .vend_fault(vend_fault),
        .busy(busy), .credit(credit)
    );

    vend_ctrl #(
        .PRICE(40), .MAX_CREDIT(40), .TIMEOUT(TIMEOUT)
    ) dut40 (
        .clk(clk), .reset_n(reset_n),
        .coin_5(coin_5), .coin_10(coin_10),
        .cancel(cancel), .dispense_done(dispense_done),
        .dispense_req(dreq2), .change_5(chg2),
        .coin_reject(rej2), .vend_fault(fault2),
        .busy(busy2), .credit(credit2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "tb hang");
    end

    task automatic mdl_reset();
        m_mode = M_OPEN; m_credit = 0; m_age = 0;
        m_gap = 0; m_chg = 0; m_rej = 0; m_fault = 0;
    endtask

    task automatic mdl_step(input bit c5, input bit c10,
                            input bit cn, input bit dd);
        int add;
        m_chg = 0; m_rej = 0; m_fault = 0;
        case (m_mode)
            M_OPEN: begin
                if (cn && m_credit > 0) begin
                    m_mode = M_PAY; m_gap = 0; m_rej = c5 | c10;
                end else begin
                    add = 0;
                    if (c10) begin
                        if (m_credit + 10 <= MAX_CREDIT) add = 10;
                        else m_rej = 1;
                    end
                    if (c5) begin
                        if (c10 || m_credit + 5 > MAX_CREDIT) m_rej = 1;
                        else add = 5;
                    end
                    m_credit += add;
                    if (m_credit >= PRICE) begin
                        m_mode = M_VEND; m_age = 0;
                    end
                end
            end
            M_VEND: begin
                m_rej = c5 | c10;
                m_age++;
                if (dd) begin
                    m_credit -= PRICE;
                    m_mode = (m_credit > 0) ? M_PAY : M_OPEN;
                    m_gap = 0;
                end else if (TMO && m_age >= TIMEOUT) begin
                    m_fault = 1; m_mode = M_PAY; m_gap = 0;
                end
            end
            default: begin
                m_rej = c5 | c10;
                if (!m_gap) begin
                    m_chg = 1; m_credit -= 5; m_gap = 1;
                    if (m_credit == 0) m_mode = M_OPEN;
                end else begin
                    m_gap = 0;
                end
            end
        endcase
    endtask

    task automatic step(input bit c5, input bit c10,
                        input bit cn, input bit dd);
        coin_5 = c5; coin_10 = c10; cancel = cn; dispense_done = dd;
        mdl_step(c5, c10, cn, dd);
        @(posedge clk); #1;
        coin_5 = 0; coin_10 = 0; cancel = 0; dispense_done = 0;
    endtask

    task automatic chk(input string nm, input int ec, input bit ed,
                       input bit ech, input bit erj, input bit ebs,
                       input bit eft);
        checks++;
        if (credit !== 6'(ec) || dispense_req !== ed || change_5 !== ech ||
            coin_reject !== erj || busy !== ebs || vend_fault !== eft) begin
            failures++;
            $display("FAIL %s: got cr=%0d dreq=%b chg=%b rej=%b busy=%b flt=%b want cr=%0d dreq=%b chg=%b rej=%b busy=%b flt=%b",
                     nm, credit, dispense_req, change_5, coin_reject, busy,
                     vend_fault, ec, ed, ech, erj, ebs, eft);
        end
    endtask

    task automatic chk40(input string nm, input int ec, input bit ed,
                         input bit erj, input bit ebs);
        checks++;
        if (credit2 !== 6'(ec) || dreq2 !== ed || rej2 !== erj ||
            busy2 !== ebs || chg2 !== 1'b0 || fault2 !== 1'b0) begin
            failures++;
            $display("FAIL %s: got cr=%0d dreq=%b rej=%b busy=%b chg=%b flt=%b want cr=%0d dreq=%b rej=%b busy=%b",
                     nm, credit2, dreq2, rej2, busy2, chg2, fault2,
                     ec, ed, erj, ebs);
        end
    endtask

    task automatic chk_model(input string nm);
        chk(nm, m_credit, m_mode == M_VEND, m_chg, m_rej,
            m_mode != M_OPEN, m_fault);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("in_reset", 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        mdl_reset();
        chk("after_reset", 0, 0, 0, 0, 0, 0);
    endtask

    typedef struct packed {
        logic       c5, c10, cn, dd;
        logic [5:0] cr;
        logic       dr, ch, rj, bs;
    } vec_t;

    vec_t tbl [23];

    initial begin
        coin_5 = 0; coin_10 = 0; cancel = 0; dispense_done = 0;
        reset_n = 1'b0;
        mdl_reset();

        //           c5 c10 cn dd  cr  dr ch rj bs
        tbl[0]  = '{1, 0, 0, 0,  5, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 15, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 20, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 0, 0, 25, 1, 0, 0, 1};
        tbl[4]  = '{0, 0, 0, 1,  0, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[6]  = '{0, 1, 0, 0, 10, 0, 0, 0, 0};
        tbl[7]  = '{0, 1, 0, 0, 20, 0, 0, 0, 0};
        tbl[8]  = '{0, 1, 0, 0, 30, 1, 0, 0, 1};
        tbl[9]  = '{0, 0, 0, 1,  5, 0, 0, 0, 1};
        tbl[10] = '{0, 0, 0, 0,  0, 0, 1, 0, 0};
        tbl[11] = '{0, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[12] = '{0, 1, 0, 0, 10, 0, 0, 0, 0};
        tbl[13] = '{0, 1, 0, 0, 20, 0, 0, 0, 0};
        tbl[14] = '{1, 0, 0, 0, 25, 1, 0, 0, 1};
        tbl[15] = '{0, 1, 0, 0, 25, 1, 0, 1, 1};
        tbl[16] = '{0, 0, 0, 1,  0, 0, 0, 0, 0};
        tbl[17] = '{1, 1, 0, 0, 10, 0, 0, 1, 0};
        tbl[18] = '{0, 0, 1, 0, 10, 0, 0, 0, 1};
        tbl[19] = '{0, 0, 0, 0,  5, 0, 1, 0, 1};
        tbl[20] = '{0, 0, 0, 0,  5, 0, 0, 0, 1};
        tbl[21] = '{0, 0, 0, 0,  0, 0, 1, 0, 0};
        tbl[22] = '{0, 0, 1, 0,  0, 0, 0, 0, 0};

        repeat (2) @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].c5, tbl[i].c10, tbl[i].cn, tbl[i].dd);
            chk($sformatf("tbl%0d", i), int'(tbl[i].cr), tbl[i].dr,
                tbl[i].ch, tbl[i].rj, tbl[i].bs, 1'b0);
        end

        // ceiling reject and exact-ceiling vend on a PRICE=40 unit
        do_reset();
        step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        chk40("p40_35", 35, 0, 0, 0);
        step(0, 1, 0, 0);
        chk40("p40_over", 35, 0, 1, 0);
        step(1, 0, 0, 0);
        chk40("p40_vend", 40, 1, 0, 1);
        step(0, 0, 0, 1);
        chk40("p40_done", 0, 0, 0, 0);

        // cancel beats a coin, then three refund pulses two cycles apart
        do_reset();
        step(1, 0, 0, 0); step(0, 1, 0, 0);
        step(1, 0, 1, 0);
        chk("cancel_coin", 15, 0, 0, 1, 1, 0);
        for (int j = 0; j < 6; j++) begin
            int ec;
            ec = 15 - 5 * (j / 2 + 1);
            step(0, 0, 0, 0);
            chk($sformatf("refund%0d", j), ec, 0, (j % 2) == 0, 0,
                ec != 0, 0);
        end

        // stuck dispense
        do_reset();
        step(0, 1, 0, 0); step(0, 1, 0, 0); step(1, 0, 0, 0);
        chk("stuck_enter", 25, 1, 0, 0, 1, 0);
`ifdef VEND_TIMEOUT_EN
        for (int j = 1; j < TIMEOUT; j++) begin
            step(0, 0, 0, 0);
            chk($sformatf("tmo_wait%0d", j), 25, 1, 0, 0, 1, 0);
        end
        step(0, 0, 0, 0);
        chk("tmo_expire", 25, 0, 0, 0, 1, 1);
        for (int j = 0; j < 10; j++) begin
            int ec;
            ec = 25 - 5 * (j / 2 + 1);
            step(0, 0, 0, 0);
            chk($sformatf("tmo_pay%0d", j), ec, 0, (j % 2) == 0, 0,
                ec != 0, 0);
        end
`else
        for (int j = 0; j < 40; j++) step(0, 0, 0, 0);
        chk("no_tmo_hold", 25, 1, 0, 0, 1, 0);
        step(0, 0, 0, 1);
        chk("no_tmo_done", 0, 0, 0, 0, 0, 0);
`endif

        // reset pulse in the middle of paying change
        do_reset();
        step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        chk("mid_change", 5, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("mid_change_pulse", 0, 0, 1, 0, 0, 0);
        do_reset();
        step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_async", 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        mdl_reset();
        step(0, 0, 0, 0);
        chk("rst_release", 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("rst_quiet", 0, 0, 0, 0, 0, 0);

        // randomized run against the model
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                reset_n = 1'b0;
                #1;
                chk("rand_rst", 0, 0, 0, 0, 0, 0);
                @(posedge clk); #1;
                reset_n = 1'b1;
                mdl_reset();
            end else begin
                bit c5, c10, cn, dd;
                c5  = ($urandom_range(0, 3) == 0);
                c10 = ($urandom_range(0, 3) == 0);
                cn  = ($urandom_range(0, 9) == 0);
                dd  = TMO ? ($urandom_range(0, 23) == 0)
                          : ($urandom_range(0, 3) == 0);
                step(c5, c10, cn, dd);
                chk_model("rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
